// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single data-memory port.
// Grant and memory mux are combinational; the load response is registered.
module dmem_arbiter #(
    parameter int BITNESS   = 32,
    parameter int MAX_BURST = 4,
    parameter int CNT_WIDTH = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [1:0]         req_i,
    input  logic [1:0]         we_i,
    input  logic [BITNESS-1:0] addr0_i,
    input  logic [BITNESS-1:0] addr1_i,
    input  logic [BITNESS-1:0] wdata0_i,
    input  logic [BITNESS-1:0] wdata1_i,
    input  logic [2:0]         ctrl0_i,
    input  logic [2:0]         ctrl1_i,
    output logic [1:0]         gnt_o,
    output logic [1:0]         rvalid_o,
    output logic [BITNESS-1:0] rdata_o,
    output logic [BITNESS-1:0] mem_addr_o,
    output logic [BITNESS-1:0] mem_wdata_o,
    output logic               mem_we_o,
    output logic [2:0]         mem_ctrl_o,
    input  logic [BITNESS-1:0] mem_rdata_i,
    output logic               busy_o
);

    localparam logic [CNT_WIDTH-1:0] BurstMax = CNT_WIDTH'(MAX_BURST);

    logic                 ownerVld_q, ownerVld_d;
    logic                 owner_q, owner_d;
    logic                 last_q, last_d;
    logic [CNT_WIDTH-1:0] burstCnt_q, burstCnt_d;
    logic [1:0]           rvalid_q, rvalid_d;
    logic [BITNESS-1:0]   rdata_q, rdata_d;

    logic                 gntAny;
    logic                 gntPort;

    // Grant is forced off while reset is held so no write can slip through.
    always_comb begin
        gntAny  = 1'b0;
        gntPort = 1'b0;
        if (!rst_i) begin
            case (req_i)
                2'b01: begin
                    gntAny  = 1'b1;
                    gntPort = 1'b0;
                end
                2'b10: begin
                    gntAny  = 1'b1;
                    gntPort = 1'b1;
                end
                2'b11: begin
                    gntAny = 1'b1;
                    if (ownerVld_q && (burstCnt_q < BurstMax)) begin
                        gntPort = owner_q;
                    end else begin
                        gntPort = ~last_q;
                    end
                end
                default: begin
                    gntAny  = 1'b0;
                    gntPort = 1'b0;
                end
            endcase
        end
    end

    assign gnt_o = gntAny ? (gntPort ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_we_o    = 1'b0;
        mem_ctrl_o  = 3'b010;
        if (gntAny) begin
            mem_addr_o  = gntPort ? addr1_i  : addr0_i;
            mem_wdata_o = gntPort ? wdata1_i : wdata0_i;
            mem_ctrl_o  = gntPort ? ctrl1_i  : ctrl0_i;
            mem_we_o    = we_i[gntPort];
        end
    end

    always_comb begin
        ownerVld_d = ownerVld_q;
        owner_d    = owner_q;
        last_d     = last_q;
        burstCnt_d = burstCnt_q;
        rvalid_d   = 2'b00;
        rdata_d    = rdata_q;
        if (gntAny) begin
            ownerVld_d = 1'b1;
            owner_d    = gntPort;
            last_d     = gntPort;
            // A new owner starts a fresh burst; the same owner counts up and saturates.
            if (!ownerVld_q || (gntPort != owner_q)) begin
                burstCnt_d = CNT_WIDTH'(1);
            end else if (burstCnt_q >= BurstMax) begin
                burstCnt_d = BurstMax;
            end else begin
                burstCnt_d = burstCnt_q + CNT_WIDTH'(1);
            end
            if (!we_i[gntPort]) begin
                rvalid_d = gntPort ? 2'b10 : 2'b01;
                rdata_d  = mem_rdata_i;
            end
        end else begin
            ownerVld_d = 1'b0;
            burstCnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ownerVld_q <= 1'b0;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            burstCnt_q <= '0;
            rvalid_q   <= 2'b00;
            rdata_q    <= '0;
        end else begin
            ownerVld_q <= ownerVld_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            burstCnt_q <= burstCnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign busy_o   = ownerVld_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a driver pushes expected grants and load
// responses from a behavioural model, a negedge monitor pops and compares.
module tb_dmem_arbiter;

    localparam int BITNESS   = 32;
    localparam int MAX_BURST = 4;
    localparam int CNT_WIDTH = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, we;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [2:0]  ctrl0, ctrl1;
    logic [1:0]  gnt, rvalid;
    logic [31:0] rdata, memAddr, memWdata, memRdata;
    logic        memWe, busy;
    logic [2:0]  memCtrl;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    dmem_arbiter #(.BITNESS(BITNESS), .MAX_BURST(MAX_BURST), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .ctrl0_i(ctrl0), .ctrl1_i(ctrl1), .gnt_o(gnt), .rvalid_o(rvalid),
        .rdata_o(rdata), .mem_addr_o(memAddr), .mem_wdata_o(memWdata),
        .mem_we_o(memWe), .mem_ctrl_o(memCtrl), .mem_rdata_i(memRdata), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Stand-in for datamemory: combinational read data derived from the address.
    function automatic logic [31:0] memFn(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    assign memRdata = memFn(memAddr);

    typedef struct {
        int          cyc;
        logic [1:0]  gnt;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [2:0]  ctrl;
        logic        busy;
    } gntExp_t;

    typedef struct {
        int          due;
        logic [1:0]  rv;
        logic [31:0] data;
    } rspExp_t;

    gntExp_t     gntQ[$];
    rspExp_t     rspQ[$];
    logic [31:0] heldExp = '0;

    int mLast  = 1;
    int mOwner = 0;
    int mRun   = 0;
    bit mValid = 0;
    int lastGrant = -1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    task automatic modelReset();
        mLast   = 1;
        mOwner  = 0;
        mRun    = 0;
        mValid  = 0;
        heldExp = '0;
        lastGrant = -1;
        gntQ.delete();
        rspQ.delete();
    endtask

    // Drives one cycle of requests and records what the arbiter must do with them.
    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] d0, input logic [31:0] d1,
                                 input logic [2:0] c0, input logic [2:0] c1);
        gntExp_t e;
        rspExp_t x;
        int g;
        @(posedge clk);
        #1;
        req = r; we = w; addr0 = a0; addr1 = a1;
        wdata0 = d0; wdata1 = d1; ctrl0 = c0; ctrl1 = c1;
        cyc++;
        g = -1;
        if (r == 2'b01) g = 0;
        else if (r == 2'b10) g = 1;
        else if (r == 2'b11) g = (mValid && mRun < MAX_BURST) ? mOwner : 1 - mLast;
        e.cyc = cyc; e.gnt = 2'b00; e.addr = '0; e.wdata = '0;
        e.we = 1'b0; e.ctrl = 3'b010; e.busy = mValid;
        if (g == 0) begin
            e.gnt = 2'b01; e.addr = a0; e.wdata = d0; e.we = w[0]; e.ctrl = c0;
        end else if (g == 1) begin
            e.gnt = 2'b10; e.addr = a1; e.wdata = d1; e.we = w[1]; e.ctrl = c1;
        end
        gntQ.push_back(e);
        if (g >= 0 && !w[g]) begin
            x.due  = cyc + 1;
            x.rv   = (g == 1) ? 2'b10 : 2'b01;
            x.data = memFn((g == 1) ? a1 : a0);
            rspQ.push_back(x);
        end
        if (g >= 0) begin
            mRun   = (mValid && g == mOwner) ? ((mRun < MAX_BURST) ? mRun + 1 : MAX_BURST) : 1;
            mOwner = g;
            mLast  = g;
            mValid = 1;
        end else begin
            mValid = 0;
            mRun   = 0;
        end
        lastGrant = g;
    endtask

    gntExp_t me;
    rspExp_t mr;

    always @(negedge clk) begin
        if (!rst) begin
            if (gntQ.size() > 0 && gntQ[0].cyc == cyc) begin
                me = gntQ.pop_front();
                checkOutput("gnt", 32'(gnt), 32'(me.gnt));
                checkOutput("mem_addr", memAddr, me.addr);
                checkOutput("mem_wdata", memWdata, me.wdata);
                checkOutput("mem_we", 32'(memWe), 32'(me.we));
                checkOutput("mem_ctrl", 32'(memCtrl), 32'(me.ctrl));
                checkOutput("busy", 32'(busy), 32'(me.busy));
            end
            if (rvalid != 2'b00) begin
                if (rspQ.size() == 0) begin
                    checkOutput("rvalid_spurious", 32'(rvalid), 32'h0);
                end else begin
                    mr = rspQ.pop_front();
                    checkOutput("rvalid_time", 32'(cyc), 32'(mr.due));
                    checkOutput("rvalid", 32'(rvalid), 32'(mr.rv));
                    checkOutput("rdata", rdata, mr.data);
                    heldExp = mr.data;
                end
            end else begin
                checkOutput("rdata_hold", rdata, heldExp);
                if (rspQ.size() > 0 && rspQ[0].due <= cyc) begin
                    mr = rspQ.pop_front();
                    checkOutput("rvalid_missing", 32'(rvalid), 32'(mr.rv));
                end
            end
        end
    end

    logic [1:0]  rr, rw;
    logic [31:0] ra0, ra1, rd0, rd1;
    logic [2:0]  rc0, rc1;

    initial begin
        rst = 1'b1;
        req = 2'b11; we = 2'b11;
        addr0 = 32'h40; addr1 = 32'h80; wdata0 = 32'h1; wdata1 = 32'h2;
        ctrl0 = 3'b000; ctrl1 = 3'b001;
        #13;
        checkOutput("reset_gnt", 32'(gnt), 32'h0);
        checkOutput("reset_mem_we", 32'(memWe), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_rvalid", 32'(rvalid), 32'h0);
        checkOutput("reset_rdata", rdata, 32'h0);
        req = 2'b00; we = 2'b00;
        #1 rst = 1'b0;
        modelReset();

        // Single load from port 0.
        applyStimulus(2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0, 3'b010, 3'b010);

        // Asynchronous reset with the load response pending.
        @(posedge clk);
        #2;
        rst = 1'b1;
        req = 2'b11; we = 2'b11;
        #1;
        checkOutput("async_rst_rvalid", 32'(rvalid), 32'h0);
        checkOutput("async_rst_gnt", 32'(gnt), 32'h0);
        checkOutput("async_rst_mem_we", 32'(memWe), 32'h0);
        checkOutput("async_rst_busy", 32'(busy), 32'h0);
        checkOutput("async_rst_rdata", rdata, 32'h0);
        modelReset();
        req = 2'b00; we = 2'b00;
        @(posedge clk);
        #3 rst = 1'b0;

        // Both ports request continuously: bursts of MAX_BURST alternate, port 0 first.
        for (int i = 0; i < 12; i++)
            applyStimulus(2'b11, 2'b00, 32'h100 + 32'(i), 32'h200 + 32'(i), '0, '0, 3'b010, 3'b100);
        applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 3'b000, 3'b000);

        // Port 1 alone for ten loads is never throttled.
        for (int i = 0; i < 10; i++)
            applyStimulus(2'b10, 2'b00, '0, 32'h300 + 32'(4 * i), '0, '0, 3'b000, 3'b010);
        applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 3'b000, 3'b000);

        // Port 0 store while port 1 loads; port 0 already owns the port.
        applyStimulus(2'b01, 2'b00, 32'h24, '0, '0, '0, 3'b010, 3'b010);
        applyStimulus(2'b11, 2'b01, 32'h20, 32'h44, 32'h0000_00AB, '0, 3'b000, 3'b010);
        applyStimulus(2'b10, 2'b00, '0, 32'h44, '0, '0, 3'b000, 3'b010);
        applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 3'b000, 3'b000);

        // Port 0 drops mid-burst while port 1 waits.
        applyStimulus(2'b11, 2'b00, 32'h50, 32'h60, '0, '0, 3'b010, 3'b010);
        applyStimulus(2'b11, 2'b00, 32'h54, 32'h60, '0, '0, 3'b010, 3'b010);
        applyStimulus(2'b10, 2'b00, '0, 32'h60, '0, '0, 3'b010, 3'b010);
        applyStimulus(2'b10, 2'b10, '0, 32'h64, '0, 32'h77, 3'b010, 3'b010);

        // Random traffic; a requester that was not granted holds its fields.
        rr = 2'b00; rw = 2'b00;
        ra0 = '0; ra1 = '0; rd0 = '0; rd1 = '0; rc0 = '0; rc1 = '0;
        for (int i = 0; i < 400; i++) begin
            if (!(rr[0] && lastGrant != 0)) begin
                rr[0] = ($urandom_range(0, 9) < 7);
                rw[0] = $urandom_range(0, 1) == 1;
                ra0 = $urandom; rd0 = $urandom; rc0 = 3'($urandom_range(0, 7));
            end
            if (!(rr[1] && lastGrant != 1)) begin
                rr[1] = ($urandom_range(0, 9) < 7);
                rw[1] = $urandom_range(0, 1) == 1;
                ra1 = $urandom; rd1 = $urandom; rc1 = 3'($urandom_range(0, 7));
            end
            applyStimulus(rr, rw, ra0, ra1, rd0, rd1, rc0, rc1);
        end

        for (int i = 0; i < 3; i++)
            applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 3'b000, 3'b000);
        @(posedge clk);
        #1;
        checkOutput("rsp_drain", 32'(rspQ.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
